// File: rtl/shift_subtract_binary_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, done strobe on completion.
// Optional DIVIDER_EARLY_ZERO_EN: a zero divisor finishes after one busy cycle instead of M.
module shift_subtract_binary_divider #(
   parameter int unsigned M = 16,
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [M-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t         state;
   logic [M-1:0]   q_shift;
   logic [N-1:0]   dvsr;
   logic [N-1:0]   rem;
   logic [CW-1:0]  cnt;
   logic           dz;

   logic [N:0]     r_trial;
   logic           fits;
   logic [N-1:0]   rem_nxt;
   logic [M-1:0]   q_nxt;

   // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
   always_comb begin
      r_trial = {rem, q_shift[M-1]};
      fits    = r_trial >= {1'b0, dvsr};
      rem_nxt = fits ? N'(r_trial - {1'b0, dvsr}) : r_trial[N-1:0];
      q_nxt   = (q_shift << 1) | M'(fits);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         q_shift     <= '0;
         dvsr        <= '0;
         rem         <= '0;
         cnt         <= '0;
         dz          <= 1'b0;
      end else begin
         case (state)
            RUN: begin
`ifdef DIVIDER_EARLY_ZERO_EN
               // Zero divisor: publish the same result the full run would give, skipping iterations.
               if (dz) begin
                  quotient    <= '1;
                  remainder   <= q_shift[N-1:0];
                  div_by_zero <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end else
`endif
               begin
                  q_shift <= q_nxt;
                  rem     <= rem_nxt;
                  cnt     <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     quotient    <= q_nxt;
                     remainder   <= rem_nxt;
                     div_by_zero <= dz;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            default: begin
               // IDLE and DONE both accept a new request; DONE drops its strobe here.
               done <= 1'b0;
               if (start) begin
                  q_shift <= dividend;
                  dvsr    <= divisor;
                  rem     <= '0;
                  cnt     <= '0;
                  dz      <= (divisor == '0);
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_subtract_binary_divider.sv
// Bench for shift_subtract_binary_divider: arithmetic reference model checked every cycle plus directed literals.
module tb_shift_subtract_binary_divider;

   localparam int unsigned M = 16;
   localparam int unsigned N = 8;
`ifdef DIVIDER_EARLY_ZERO_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 16;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [M-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [M-1:0] quotient;
   logic [N-1:0] remainder;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_subtract_binary_divider #(.M(M), .N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void ref_div(input logic [M-1:0] a, input logic [N-1:0] b,
                                   output logic [M-1:0] q, output logic [N-1:0] r);
      if (b == 0) begin
         q = '1;
         r = a[N-1:0];
      end else begin
         q = a / M'(b);
         r = N'(a % M'(b));
      end
   endfunction

   // Transaction-level model: a countdown to done, results taken from plain arithmetic.
   logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
   logic [M-1:0] m_q = '0, p_q = '0;
   logic [N-1:0] m_r = '0, p_r = '0;
   int           m_left = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
         m_q = '0; m_r = '0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1; m_busy = 1'b0;
               m_q = p_q; m_r = p_r; m_dz = p_dz;
            end
         end else if (start) begin
            ref_div(dividend, divisor, p_q, p_r);
            p_dz   = (divisor == 0);
            m_left = (divisor == 0) ? ZLAT : M;
            m_busy = 1'b1;
         end
      end
   end

   always @(negedge clk)
      check("cycle{busy,done,dz,q,r}", {5'd0, busy, done, div_by_zero, quotient, remainder},
            {5'd0, m_busy, m_done, m_dz, m_q, m_r});

   task automatic do_start(input logic [M-1:0] a, input logic [N-1:0] b);
      @(posedge clk); #2;
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   // Counts edges after the acceptance edge until done is seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   task automatic run_div(input logic [M-1:0] a, input logic [N-1:0] b, input logic [M-1:0] eq,
                          input logic [N-1:0] er, input logic edz, input int elat);
      int n;
      do_start(a, b);
      wait_done(n);
      check("latency", 32'(n), 32'(elat));
      check("quotient", 32'(quotient), 32'(eq));
      check("remainder", 32'(remainder), 32'(er));
      check("div_by_zero", 32'(div_by_zero), 32'(edz));
   endtask

   initial begin
      int n;
      int d;
      logic [M-1:0] a, eq;
      logic [N-1:0] b, er;

      #1;
      check("reset_outputs", {5'd0, busy, done, div_by_zero, quotient, remainder}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;

      run_div(16'd200, 8'd7, 16'd28, 8'd4, 1'b0, 16);
      run_div(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16);
      run_div(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16);
      run_div(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, ZLAT);

      // Start pulsed while busy is ignored.
      do_start(16'd300, 8'd12);
      repeat (4) @(posedge clk);
      #2; dividend = 16'd999; divisor = 8'd3; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      wait_done(n);
      check("ignored_start_latency", 32'(n), 32'd11);
      check("ignored_start_q", 32'(quotient), 32'd25);
      check("ignored_start_r", 32'(remainder), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_q", 32'(quotient), 32'd25);
      check("hold_busy_done", {30'd0, busy, done}, 32'd0);

      // Back-to-back: start held in the done cycle.
      do_start(16'd5000, 8'd70);
      wait_done(n);
      check("b2b_first_q", 32'(quotient), 32'd71);
      check("b2b_first_r", 32'(remainder), 32'd30);
      dividend = 16'd1000; divisor = 8'd10; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      wait_done(n);
      check("b2b_latency", 32'(n), 32'd16);
      check("b2b_q", 32'(quotient), 32'd100);
      check("b2b_r", 32'(remainder), 32'd0);

      // Reset mid-division aborts with no done.
      do_start(16'd1000, 8'd3);
      repeat (7) @(posedge clk);
      #2; rst = 1'b1;
      #1;
      check("abort_outputs", {5'd0, busy, done, div_by_zero, quotient, remainder}, 32'd0);
      @(posedge clk); #2; rst = 1'b0;
      d = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) d++;
      end
      check("no_done_after_abort", 32'(d), 32'd0);
      run_div(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 16);

      // Random sweep with the division identity.
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         ref_div(a, b, eq, er);
         do_start(a, b);
         wait_done(n);
         check("sweep_q", 32'(quotient), 32'(eq));
         check("sweep_r", 32'(remainder), 32'(er));
         if (b != 0)
            check("sweep_invariant",
                  32'((int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b)),
                  32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
